// File: rtl/div_arbiter.sv
// div_arbiter: shares one combinational divider between two requesters.
// Requests are taken over valid/ready, granted round-robin, and the divider
// operands are held in registers for SETTLE cycles before the result is
// captured and returned on the granted channel. Divide-by-zero is answered
// directly (quotient all ones, remainder = dividend, dbz set).
// Optional build macro: DIV_ARB_FIXED_PRIO_EN -- channel 0 always wins a tie
// and the round-robin pointer register is removed.
module div_arbiter #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_q,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_q,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_quotient,
    output logic [WIDTH-1:0] rsp0_remainder,
    output logic             rsp0_dbz,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_quotient,
    output logic [WIDTH-1:0] rsp1_remainder,
    output logic             rsp1_dbz,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state, state_nxt;
    logic             id, id_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] q_reg_nxt, b_reg_nxt;
    logic [WIDTH-1:0] res_quo, res_quo_nxt;
    logic [WIDTH-1:0] res_rem, res_rem_nxt;
    logic             res_dbz, res_dbz_nxt;
    logic             grant;
    logic             take;
    logic             done;
    logic [WIDTH-1:0] sel_q, sel_b;

`ifdef DIV_ARB_FIXED_PRIO_EN
    // Channel 0 has absolute priority; grant goes to 1 only when 0 is idle.
    always_comb begin
        grant = !req0_valid;
    end
`else
    logic ptr;  // last channel served; a tie goes to the other one

    // Round-robin grant: on a tie pick the channel not served last.
    always_comb begin
        grant = !req0_valid;
        if (req0_valid && req1_valid)
            grant = ~ptr;
    end

    // Pointer follows the channel whose response has just been consumed.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b1;
        else if (state == RESP && done)
            ptr <= id;
    end
`endif

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign take       = req0_ready || req1_ready;
    assign sel_q      = grant ? req1_q : req0_q;
    assign sel_b      = grant ? req1_b : req0_b;
    assign done       = id ? rsp1_ready : rsp0_ready;

    assign rsp0_valid     = (state == RESP) && !id;
    assign rsp1_valid     = (state == RESP) && id;
    assign rsp0_quotient  = res_quo;
    assign rsp0_remainder = res_rem;
    assign rsp0_dbz       = res_dbz;
    assign rsp1_quotient  = res_quo;
    assign rsp1_remainder = res_rem;
    assign rsp1_dbz       = res_dbz;

    // Next-state and register-load decisions for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_nxt   = state;
        id_nxt      = id;
        cnt_nxt     = cnt;
        q_reg_nxt   = div_q;
        b_reg_nxt   = div_b;
        res_quo_nxt = res_quo;
        res_rem_nxt = res_rem;
        res_dbz_nxt = res_dbz;
        case (state)
            IDLE: begin
                if (take) begin
                    id_nxt = grant;
                    if (sel_b != '0) begin
                        q_reg_nxt = sel_q;
                        b_reg_nxt = sel_b;
                        cnt_nxt   = 4'(SETTLE - 1);
                        state_nxt = BUSY;
                    end else begin
                        // Divider is bypassed; its operand registers keep old values.
                        res_quo_nxt = '1;
                        res_rem_nxt = sel_q;
                        res_dbz_nxt = 1'b1;
                        state_nxt   = RESP;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    res_quo_nxt = div_quotient;
                    res_rem_nxt = div_remainder;
                    res_dbz_nxt = 1'b0;
                    state_nxt   = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            id      <= 1'b0;
            cnt     <= 4'd0;
            div_q   <= '0;
            div_b   <= '0;
            res_quo <= '0;
            res_rem <= '0;
            res_dbz <= 1'b0;
        end else begin
            state   <= state_nxt;
            id      <= id_nxt;
            cnt     <= cnt_nxt;
            div_q   <= q_reg_nxt;
            div_b   <= b_reg_nxt;
            res_quo <= res_quo_nxt;
            res_rem <= res_rem_nxt;
            res_dbz <= res_dbz_nxt;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: two instances (SETTLE=1 and SETTLE=4) driven by directed
// and randomized transactions; expectations come from a transaction-level
// model (grant rule, q/b arithmetic, latency from SETTLE).
module tb_div_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       rv   [2][2];
    logic       rr   [2][2];
    logic [7:0] rq   [2][2];
    logic [7:0] rb   [2][2];
    logic       sv   [2][2];
    logic       sr   [2][2];
    logic [7:0] quo  [2][2];
    logic [7:0] rem  [2][2];
    logic       dbz  [2][2];
    logic [7:0] dq   [2];
    logic [7:0] db   [2];
    logic [7:0] dquo [2];
    logic [7:0] drem [2];

    int errors = 0;
    int checks = 0;

    // model state: last served channel and last operands loaded into the divider
    int       last_g [2];
    logic [7:0] ld_q [2];
    logic [7:0] ld_b [2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int S = (d == 0) ? 1 : 4;
        div_arbiter #(.WIDTH(8), .SETTLE(S)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(rv[d][0]), .req0_ready(rr[d][0]), .req0_q(rq[d][0]), .req0_b(rb[d][0]),
            .req1_valid(rv[d][1]), .req1_ready(rr[d][1]), .req1_q(rq[d][1]), .req1_b(rb[d][1]),
            .rsp0_valid(sv[d][0]), .rsp0_ready(sr[d][0]), .rsp0_quotient(quo[d][0]),
            .rsp0_remainder(rem[d][0]), .rsp0_dbz(dbz[d][0]),
            .rsp1_valid(sv[d][1]), .rsp1_ready(sr[d][1]), .rsp1_quotient(quo[d][1]),
            .rsp1_remainder(rem[d][1]), .rsp1_dbz(dbz[d][1]),
            .div_q(dq[d]), .div_b(db[d]),
            .div_quotient(dquo[d]), .div_remainder(drem[d])
        );
        // shared combinational divider
        assign dquo[d] = (db[d] == 8'd0) ? 8'hFF : 8'(dq[d] / db[d]);
        assign drem[d] = (db[d] == 8'd0) ? dq[d] : 8'(dq[d] % db[d]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int exp_grant(input int d, input bit v0, input bit v1);
`ifdef DIV_ARB_FIXED_PRIO_EN
        return v0 ? 0 : 1;
`else
        if (v0 && v1) return 1 - last_g[d];
        return v0 ? 0 : 1;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_g[d] = 1;
            ld_q[d]   = 8'd0;
            ld_b[d]   = 8'd0;
        end
    endtask

    task automatic check_reset(input int d);
        chk("rst_rsp_valid", {sv[d][1], sv[d][0]}, 2'b00);
        chk("rst_req_ready", {rr[d][1], rr[d][0]}, 2'b00);
        chk("rst_div_q", dq[d], 8'd0);
        chk("rst_div_b", db[d], 8'd0);
        chk("rst_quotient", quo[d][0], 8'd0);
        chk("rst_remainder", rem[d][1], 8'd0);
        chk("rst_dbz", {dbz[d][1], dbz[d][0]}, 2'b00);
    endtask

    // One transaction, called at a falling edge. Checks grant, busy window,
    // response latency/data, backpressure stability and return to IDLE.
    task automatic txn(input int d, input bit v0, input logic [7:0] q0, input logic [7:0] b0,
                       input bit v1, input logic [7:0] q1, input logic [7:0] b1,
                       input int hold, input bit keep_loser);
        int g, lat;
        logic [7:0] q, b, eq, er;
        bit ez;
        rv[d][0] = v0; rq[d][0] = q0; rb[d][0] = b0;
        rv[d][1] = v1; rq[d][1] = q1; rb[d][1] = b1;
        #1;
        g = exp_grant(d, v0, v1);
        chk("grant_ready", {rr[d][1], rr[d][0]}, (g == 1) ? 2'b10 : 2'b01);
        q  = (g == 1) ? q1 : q0;
        b  = (g == 1) ? b1 : b0;
        ez = (b == 8'd0);
        eq = ez ? 8'hFF : 8'(q / b);
        er = ez ? q : 8'(q % b);
        lat = ez ? 1 : settle_of(d) + 1;
        @(posedge clk); #1;
        rv[d][g] = 1'b0;
        if (!keep_loser) rv[d][1-g] = 1'b0;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("busy_rsp_valid", {sv[d][1], sv[d][0]}, 2'b00);
            chk("busy_req_ready", {rr[d][1], rr[d][0]}, 2'b00);
            chk("busy_div_q", dq[d], q);
            chk("busy_div_b", db[d], b);
        end
        if (!ez) begin
            ld_q[d] = q;
            ld_b[d] = b;
        end
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            chk("rsp_valid", {sv[d][1], sv[d][0]}, (g == 1) ? 2'b10 : 2'b01);
            chk("rsp_quotient", quo[d][g], eq);
            chk("rsp_remainder", rem[d][g], er);
            chk("rsp_dbz", dbz[d][g], ez);
            chk("rsp_req_ready", {rr[d][1], rr[d][0]}, 2'b00);
            chk("rsp_div_q", dq[d], ld_q[d]);
            chk("rsp_div_b", db[d], ld_b[d]);
        end
        sr[d][g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sr[d][g] = 1'b0;
        chk("idle_rsp_valid", {sv[d][1], sv[d][0]}, 2'b00);
        last_g[d] = g;
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                rv[d][c] = 1'b0; rq[d][c] = 8'd0; rb[d][c] = 8'd0; sr[d][c] = 1'b0;
            end
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk);

        // single request, SETTLE=1
        txn(0, 1, 8'd57, 8'd3, 0, 8'd0, 8'd0, 0, 0);
        // continuous tie: alternates under round-robin
        for (int i = 0; i < 4; i++)
            txn(0, 1, 8'd100, 8'd7, 1, 8'd255, 8'd16, 0, 1);
        // divide by zero on channel 1
        txn(0, 0, 8'd0, 8'd0, 1, 8'd42, 8'd0, 0, 0);
        // backpressure for 5 cycles
        txn(0, 1, 8'd201, 8'd13, 0, 8'd0, 8'd0, 5, 0);
        // SETTLE=4 instance
        txn(1, 1, 8'd200, 8'd9, 0, 8'd0, 8'd0, 0, 0);

        // reset pulse while instance 1 is BUSY
        rv[1][0] = 1'b1; rq[1][0] = 8'd77; rb[1][0] = 8'd5;
        @(posedge clk); #1;
        rv[1][0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {sv[1][1], sv[1][0]}, 2'b00);
        end
        txn(1, 1, 8'd100, 8'd7, 1, 8'd255, 8'd16, 0, 0);

        // randomized transactions on both instances
        for (int i = 0; i < 40; i++) begin
            int d, vs, hold;
            logic [7:0] a0, a1, c0, c1;
            d    = i % 2;
            vs   = $urandom_range(1, 3);
            a0   = 8'($urandom);
            a1   = 8'($urandom);
            c0   = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            c1   = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            hold = $urandom_range(0, 3);
            txn(d, vs[0], a0, c0, vs[1], a1, c1, hold, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequential controller that shares one combinational 8-bit divider (quotient/remainder datapath) between two requesters. Accepts operand pairs over valid/ready handshakes, arbitrates round-robin, drives the shared divider's inputs from registers, waits a fixed settle time, captures the result and returns it on the granted channel's response port. It handles divide-by-zero itself without using the divider.

## Interface
- WIDTH, 8, operand/result width; the divider port widths match it.
- SETTLE, 1, number of BUSY cycles the divider inputs are held before capture; legal range 1..15.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester N has an operand pair.
- req0_ready / req1_ready  out  1  request N is accepted this cycle.
- req0_q, req0_b / req1_q, req1_b  in  WIDTH  dividend and divisor.
- rsp0_valid / rsp1_valid  out  1  result for requester N is available.
- rsp0_ready / rsp1_ready  in  1  requester N consumes the result.
- rsp0_quotient, rsp0_remainder / rsp1_*  out  WIDTH  result.
- rsp0_dbz / rsp1_dbz  out  1  divisor was zero.
- div_q, div_b  out  WIDTH  registered operands to the shared divider.
- div_quotient, div_remainder  in  WIDTH  combinational divider outputs.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - grant = requester with valid high; on a tie, the one not granted last (round-robin pointer).
  - req<g>_ready = 1 combinationally for the granted channel only; the other ready = 0.
  - On handshake, latch the channel id. If b != 0: load div_q/div_b, load the counter with SETTLE-1, go to BUSY. If b == 0: load quotient = all ones, remainder = q, dbz = 1, go to RESP.
- BUSY:
  - div_q/div_b are held stable.
  - Counter decrements each cycle. In the cycle the counter is 0, capture div_quotient/div_remainder into the result registers with dbz = 0, then go to RESP.
- RESP:
  - rsp<id>_valid = 1; result registers drive both channels' data outputs. The other channel's valid = 0.
  - On rsp<id>_ready, update the round-robin pointer to id and go to IDLE.
- All req*_ready = 0 outside IDLE. One transaction is in flight at a time; no queuing.
- Requesters must not make valid depend on ready. Valid and operands hold until the handshake.

## Timing
- Reset values: state IDLE, all rsp*_valid = 0, all req*_ready = 0 (no valid), result registers 0, rsp*_dbz = 0, div_q = div_b = 0, round-robin pointer = channel 1, so channel 0 wins the first tie.
- Normal latency: handshake at edge N; BUSY occupies cycles N+1..N+SETTLE; rsp_valid is high from cycle N+SETTLE+1.
- Divide-by-zero latency: rsp_valid is high from cycle N+1; the divider is not loaded and div_q/div_b keep their old values.
- rsp_valid stays high, with data stable, until rsp_ready. Completion at edge M gives IDLE at M+1, so the earliest next acceptance is in cycle M+1.
- No combinational path from rsp_ready to req_ready within the same cycle.
- rst asserted in any state: the next edge returns everything to reset values. An in-flight transaction is dropped with no response, and the pointer is reset.

## Configuration
- DIV_ARB_FIXED_PRIO_EN
  - Defined: channel 0 always wins when both are valid, and the pointer register is removed.
  - Undefined (default): round-robin as specified above.

## Test plan
- Single request: req0 q=57, b=3, SETTLE=1, rsp0_ready tied high -> rsp0_valid in cycle N+2, quotient 19, remainder 0, dbz 0. rsp1_valid never asserts.
- Tie arbitration: both valid continuously, ch0 q=100 b=7 and ch1 q=255 b=16 -> grant order ch0, ch1, ch0, ch1 with results 14r2 and 15r15. Under DIV_ARB_FIXED_PRIO_EN, ch0 is served every time.
- Divide by zero: req1 q=42, b=0 -> rsp1_valid at N+1, quotient 255, remainder 42, dbz 1. div_q/div_b are unchanged.
- Backpressure: rsp0_ready held low for 5 cycles -> rsp0_valid and data stable throughout, both req*_ready = 0. Release gives IDLE on the next cycle.
- Settle: SETTLE=4, q=200, b=9 -> div_b = 9 held for 4 cycles, rsp valid at N+5, result 22r2.
- Reset mid-BUSY: rst pulsed during BUSY -> no response is issued, all outputs at reset values, and the next ch0/ch1 tie grants ch0.
